// File: rtl/memory_address_frontend.sv
`default_nettype none
// ============================================================================
// Module   : memory_address_frontend
// Brief    : MAR plus front-panel manual programming front end for a 16x8 RAM
// Revision : 1.0 - initial release
// ============================================================================
module memory_address_frontend #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit AUTO_INC        = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_address,
    input  logic [7:0] bus_in,
    input  logic       manual_mode_switch,
    input  logic       write_button,
    input  logic [3:0] address_switches,
    output logic [3:0] address,
    output logic       manual_mode,
    output logic       manual_read
);

    localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    // Debounce channel index: 0 = mode switch, 1 = write button
    localparam int c_CH_MODE = 0;
    localparam int c_CH_BTN  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t r_state, w_state_next;

    logic [1:0]         r_mode_sync;
    logic [1:0]         r_btn_sync;
    logic [3:0]         r_sw_s1;
    logic [3:0]         r_sw_s2;
    logic [3:0]         r_sw_prev;
    logic [1:0]         r_db;
    logic [c_CNT_W-1:0] r_cnt [2];
    logic               r_btn_db_d;
    logic [3:0]         r_mar;
    logic [3:0]         r_ptr;

    logic [1:0]         w_sync;
    logic [1:0]         w_flip;
    logic               w_mode_rise;
    logic               w_sw_change;
    logic               w_btn_rise;
    logic               w_bus_unused;

    assign w_bus_unused = ^bus_in[7:4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_sync <= '0;
            r_btn_sync  <= '0;
            r_sw_s1     <= '0;
            r_sw_s2     <= '0;
            r_sw_prev   <= '0;
        end else begin
            r_mode_sync <= {r_mode_sync[0], manual_mode_switch};
            r_btn_sync  <= {r_btn_sync[0], write_button};
            r_sw_s1     <= address_switches;
            r_sw_s2     <= r_sw_s1;
            r_sw_prev   <= r_sw_s2;
        end
    end

    assign w_sync[c_CH_MODE] = r_mode_sync[1];
    assign w_sync[c_CH_BTN]  = r_btn_sync[1];

    // A channel flips once it has differed for DEBOUNCE_CYCLES consecutive samples
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_flip[i] = (w_sync[i] != r_db[i]) && (r_cnt[i] == c_CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_sync[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_flip[i]) begin
                    r_cnt[i] <= '0;
                    r_db[i]  <= w_sync[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_mode_rise = w_flip[c_CH_MODE] & w_sync[c_CH_MODE];
    assign w_sw_change = (r_sw_s2 != r_sw_prev);
    assign w_btn_rise  = r_db[c_CH_BTN] & ~r_btn_db_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_db_d <= 1'b0;
            r_mar      <= '0;
            r_ptr      <= '0;
        end else begin
            r_btn_db_d <= r_db[c_CH_BTN];
            if (load_address && !r_db[c_CH_MODE]) begin
                r_mar <= bus_in[3:0];
            end
            // Switch activity wins over the post-write increment
            if (w_mode_rise || w_sw_change) begin
                r_ptr <= r_sw_s2;
            end else if (AUTO_INC && (r_state == ST_WRITE) && r_db[c_CH_MODE]) begin
                r_ptr <= r_ptr + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_btn_rise) w_state_next = ST_WRITE;
            ST_WRITE: w_state_next = ST_HOLD;
            ST_HOLD:  if (!r_db[c_CH_BTN]) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
        // Leaving manual mode aborts any write sequence and blocks queued presses
        if (!r_db[c_CH_MODE]) begin
            w_state_next = ST_IDLE;
        end
    end

    assign manual_mode = r_db[c_CH_MODE];
    assign manual_read = (r_state == ST_WRITE) & r_db[c_CH_MODE];
    assign address     = r_db[c_CH_MODE] ? r_ptr : r_mar;

endmodule
`default_nettype wire

// File: tb/tb_memory_address_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_address_frontend
// Brief    : Directed bench; one instance with auto-increment, one without
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_address_frontend;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_address;
    logic [7:0] bus_in;
    logic       manual_mode_switch;
    logic       write_button;
    logic [3:0] address_switches;
    logic [3:0] addr1, addr0;
    logic       mm1, mm0, mr1, mr0;

    int         checks = 0;
    int         errors = 0;
    int         pulses1 = 0;
    int         pulses0 = 0;
    int         p1_snap, p0_snap;
    logic [3:0] sb [$];
    logic [3:0] exp_a;

    memory_address_frontend #(.DEBOUNCE_CYCLES(DB), .AUTO_INC(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .load_address(load_address), .bus_in(bus_in),
        .manual_mode_switch(manual_mode_switch), .write_button(write_button),
        .address_switches(address_switches), .address(addr1),
        .manual_mode(mm1), .manual_read(mr1)
    );

    memory_address_frontend #(.DEBOUNCE_CYCLES(DB), .AUTO_INC(1'b0)) dut_noinc (
        .clk(clk), .rst_n(rst_n), .load_address(load_address), .bus_in(bus_in),
        .manual_mode_switch(manual_mode_switch), .write_button(write_button),
        .address_switches(address_switches), .address(addr0),
        .manual_mode(mm0), .manual_read(mr0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every write strobe of the auto-increment instance pops one expected address
    always @(negedge clk) begin
        if (mr0 === 1'b1) pulses0++;
        if (mr1 === 1'b1) begin
            pulses1++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $error("FAIL unexpected_write observed_addr=%0h expected=no_write", addr1);
            end else begin
                exp_a = sb.pop_front();
                assert (addr1 === exp_a) else begin
                    errors++;
                    $error("FAIL write_addr observed=%0h expected=%0h", addr1, exp_a);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with random inputs
        rst_n              = 1'b0;
        load_address       = 1'($urandom);
        bus_in             = 8'($urandom);
        manual_mode_switch = 1'($urandom);
        write_button       = 1'($urandom);
        address_switches   = 4'($urandom);
        tick(3);
        check("rst_address", addr1, 4'h0);
        check("rst_manual_mode", mm1, 1'b0);
        check("rst_manual_read", mr1, 1'b0);

        load_address       = 1'b1;
        bus_in             = 8'hA7;
        manual_mode_switch = 1'b0;
        write_button       = 1'b0;
        address_switches   = 4'h0;
        rst_n              = 1'b1;
        tick(1);
        check("mar_load", addr1, 4'h7);
        load_address       = 1'b0;
        address_switches   = 4'hE;
        tick(4);

        // 3-cycle glitch on the mode switch must be rejected
        manual_mode_switch = 1'b1;
        tick(3);
        manual_mode_switch = 1'b0;
        tick(10);
        check("mode_glitch", mm1, 1'b0);

        // Clean mode change lands exactly DB+2 edges later
        manual_mode_switch = 1'b1;
        tick(DB + 1);
        check("mode_early", mm1, 1'b0);
        tick(1);
        check("mode_on", mm1, 1'b1);
        check("ptr_seed", addr1, 4'hE);

        // load_address ignored in manual mode
        load_address = 1'b1;
        bus_in       = 8'h05;
        tick(2);
        load_address = 1'b0;
        check("ptr_kept_on_load", addr1, 4'hE);

        // First write at E, then pointer advances to F
        write_button = 1'b1;
        sb.push_back(4'hE);
        tick(DB + 2);
        check("write_not_yet", mr1, 1'b0);
        tick(1);
        check("write_strobe", mr1, 1'b1);
        check("write_strobe_addr", addr1, 4'hE);
        tick(1);
        check("write_one_cycle", mr1, 1'b0);
        check("ptr_incr", addr1, 4'hF);
        check("ptr_noinc", addr0, 4'hE);
        write_button = 1'b0;
        tick(8);

        // Second write at F wraps the pointer to 0
        write_button = 1'b1;
        sb.push_back(4'hF);
        tick(DB + 3);
        check("write2_strobe", mr1, 1'b1);
        check("write2_addr", addr1, 4'hF);
        tick(1);
        check("ptr_wrap", addr1, 4'h0);
        write_button = 1'b0;
        tick(8);

        // Bouncy press then a long hold: one write only
        p1_snap = pulses1;
        p0_snap = pulses0;
        sb.push_back(4'h0);
        for (int i = 0; i < 58; i++) begin
            write_button = (i < 8) ? (((i / 2) % 2) == 0) : 1'b1;
            tick(1);
        end
        write_button = 1'b0;
        tick(8);
        check("held_pulses", 8'(pulses1 - p1_snap), 8'd1);
        check("held_pulses_noinc", 8'(pulses0 - p0_snap), 8'd1);
        check("held_ptr", addr1, 4'h1);
        check("held_ptr_noinc", addr0, 4'hE);

        // Back to run mode: MAR preserved, presses ignored
        manual_mode_switch = 1'b0;
        tick(DB + 1);
        check("mode_off_early", mm1, 1'b1);
        tick(1);
        check("mode_off", mm1, 1'b0);
        check("mar_retained", addr1, 4'h7);
        p1_snap = pulses1;
        p0_snap = pulses0;
        write_button = 1'b1;
        tick(10);
        check("run_no_strobe", mr1, 1'b0);
        write_button = 1'b0;
        tick(8);
        check("run_press_ignored", 8'(pulses1 - p1_snap), 8'd0);
        check("run_press_ignored_noinc", 8'(pulses0 - p0_snap), 8'd0);

        // Reset asserted in the middle of a WRITE cycle
        manual_mode_switch = 1'b1;
        tick(DB + 2);
        check("mode_on2", mm1, 1'b1);
        check("ptr_reseed", addr1, 4'hE);
        write_button = 1'b1;
        tick(DB + 2);
        @(posedge clk);
        #2;
        check("pre_reset_strobe", mr1, 1'b1);
        rst_n = 1'b0;
        #1;
        check("reset_drops_strobe", mr1, 1'b0);
        check("reset_address", addr1, 4'h0);
        check("reset_mode", mm1, 1'b0);
        @(negedge clk);
        manual_mode_switch = 1'b0;
        write_button       = 1'b0;
        load_address       = 1'b0;
        address_switches   = 4'h0;
        rst_n              = 1'b1;
        tick(3);
        check("post_reset_address", addr1, 4'h0);
        check("post_reset_strobe", mr1, 1'b0);
        check("post_reset_noinc_addr", addr0, 4'h0);
        check("scoreboard_empty", 8'(sb.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
